// File: rtl/uart_rx_if.sv
// Byte-stream handshake from the UART receiver toward the core,
// plus the single-cycle framing-error and overrun status pulses.
interface uart_rx_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;

    modport master (output valid, output data, output frame_err, output overrun, input ready);
    modport slave  (input valid, input data, input frame_err, input overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, valid/ready output
// with single-cycle frame-error and overrun pulses.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | timing to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB first at mid bit
// STOP  | timing to mid stop bit, then deliver or flag
module uart_rx #(
    parameter int unsigned BaudRate  = 115200,
    parameter int unsigned ClockFreq = 12000000
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      rx_i,
    uart_rx_if.master out_if
);

    localparam int unsigned CyclesPerBaud = ClockFreq / BaudRate;
    localparam logic [23:0] BaudLast      = 24'(CyclesPerBaud - 1);
    localparam logic [23:0] HalfLast      = 24'(CyclesPerBaud / 2 - 1);

    if (CyclesPerBaud < 4) begin : g_cfg_check
        $error("uart_rx: CyclesPerBaud must be at least 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e      state;
    logic [1:0]  sync;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            sync             <= 2'b11;
            baud_cnt         <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            out_if.valid     <= 1'b0;
            out_if.data      <= 8'h00;
            out_if.frame_err <= 1'b0;
            out_if.overrun   <= 1'b0;
        end else begin
            sync             <= {sync[0], rx_i};
            out_if.frame_err <= 1'b0;
            out_if.overrun   <= 1'b0;

            // A load in STOP below overrides this drop when both happen together.
            if (out_if.valid && out_if.ready) begin
                out_if.valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HalfLast) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BaudLast) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit lets a following start edge be caught with no idle gap.
                    if (baud_cnt == BaudLast) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rx_s) begin
                            if (!out_if.valid || out_if.ready) begin
                                out_if.data  <= shift;
                                out_if.valid <= 1'b1;
                            end else begin
                                out_if.overrun <= 1'b1;
                            end
                        end else begin
                            out_if.frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 24'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
